// File: rtl/tx_datapath.sv
// tx_datapath: one-byte holding buffer plus frame shifter feeding a serial TXD line.
//   CLK      in  system clock, all state on posedge
//   RESET    in  asynchronous active-low reset
//   DIN      in  host data byte
//   WR       in  host write strobe
//   CLR_FLG  in  clears OVERRUN and UNDERRUN
//   INCARCA  in  controller load strobe (wins over DEPL)
//   DEPL     in  controller shift strobe
//   TXD      out registered serial line, idle high
//   NUM12    out bit counter == FRAME_LEN
//   BUF_FULL out holding buffer occupied
//   OVERRUN  out sticky lost-write flag
//   UNDERRUN out sticky load-with-empty-buffer flag
module tx_datapath #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              WR,
  input  logic              CLR_FLG,
  input  logic              INCARCA,
  input  logic              DEPL,
  output logic              TXD,
  output logic              NUM12,
  output logic              BUF_FULL,
  output logic              OVERRUN,
  output logic              UNDERRUN
);
  localparam int FRAME_LEN = DATA_W + 4;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  logic [DATA_W-1:0] buf_q, buf_d, load_data;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d, frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic buf_full_q, buf_full_d;
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;
  logic active_q, active_d;
  logic txd_q, txd_d;
  logic have_data, can_shift, parity;
  always_comb begin
    have_data  = buf_full_q | WR;
    // A full buffer always feeds the frame first; a same-cycle write then refills it.
    load_data  = buf_full_q ? buf_q : DIN;
    parity     = PARITY_ODD ? ~^load_data : ^load_data;
    frame      = have_data ? {2'b11, parity, load_data, 1'b0} : '1;
    can_shift  = DEPL & (cnt_q < CNT_FULL);
    shreg_d    = INCARCA ? frame : can_shift ? {1'b1, shreg_q[FRAME_LEN-1:1]} : shreg_q;
    cnt_d      = INCARCA ? '0 : can_shift ? cnt_q + CNT_ONE : cnt_q;
    active_d   = INCARCA | (active_q & (cnt_d != CNT_FULL));
    txd_d      = active_d ? shreg_d[0] : 1'b1;
    buf_full_d = WR ? (buf_full_q | ~INCARCA) : (buf_full_q & ~INCARCA);
    buf_d      = (WR & (~buf_full_q | INCARCA)) ? DIN : buf_q;
    // Set conditions take precedence over CLR_FLG.
    overrun_d  = (WR & buf_full_q & ~INCARCA) | (overrun_q & ~CLR_FLG);
    underrun_d = (INCARCA & ~have_data) | (underrun_q & ~CLR_FLG);
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '1;
      cnt_q      <= CNT_FULL;
      active_q   <= 1'b0;
      txd_q      <= 1'b1;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      txd_q      <= txd_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end
  assign TXD      = txd_q;
  assign NUM12    = (cnt_q == CNT_FULL);
  assign BUF_FULL = buf_full_q;
  assign OVERRUN  = overrun_q;
  assign UNDERRUN = underrun_q;
endmodule

// File: tb/tb_tx_datapath.sv
// tb_tx_datapath: directed checks of tx_datapath with even and odd parity instances.
module tb_tx_datapath;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] din = '0;
  logic wr = 1'b0, clr_flg = 1'b0, incarca = 1'b0, depl = 1'b0;
  logic txd_e, num12_e, buf_full_e, overrun_e, underrun_e;
  logic txd_o, num12_o, buf_full_o, overrun_o, underrun_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] oe, oo;
  logic n12_mid, n12_end, txd_end;

  always #5 clk = ~clk;

  tx_datapath #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
    .CLK(clk), .RESET(reset_n), .DIN(din), .WR(wr), .CLR_FLG(clr_flg),
    .INCARCA(incarca), .DEPL(depl), .TXD(txd_e), .NUM12(num12_e),
    .BUF_FULL(buf_full_e), .OVERRUN(overrun_e), .UNDERRUN(underrun_e)
  );

  tx_datapath #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
    .CLK(clk), .RESET(reset_n), .DIN(din), .WR(wr), .CLR_FLG(clr_flg),
    .INCARCA(incarca), .DEPL(depl), .TXD(txd_o), .NUM12(num12_o),
    .BUF_FULL(buf_full_o), .OVERRUN(overrun_o), .UNDERRUN(underrun_o)
  );

  task automatic step(input logic w, input logic [7:0] d, input logic inc, input logic dp, input logic clr);
    wr = w; din = d; incarca = inc; depl = dp; clr_flg = clr;
    @(posedge clk); #1;
    wr = 0; incarca = 0; depl = 0; clr_flg = 0;
  endtask

  task automatic send(input logic w, input logic [7:0] d);
    wr = w; din = d; incarca = 1;
    @(posedge clk); #1;
    wr = 0; incarca = 0;
    oe[0] = txd_e; oo[0] = txd_o;
    for (int k = 1; k < 12; k++) begin
      depl = 1;
      @(posedge clk); #1;
      depl = 0;
      oe[k] = txd_e; oo[k] = txd_o;
    end
    n12_mid = num12_e;
    depl = 1;
    @(posedge clk); #1;
    depl = 0;
    n12_end = num12_e; txd_end = txd_e;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (txd_e !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd_e); end
    n_chk++; if (num12_e !== 1'b1) begin n_fail++; $display("FAIL reset_num12: got %b want 1", num12_e); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL reset_buf_full: got %b want 0", buf_full_e); end
    n_chk++; if ({overrun_e, underrun_e} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {overrun_e, underrun_e}); end
    n_chk++; if (txd_o !== 1'b1) begin n_fail++; $display("FAIL reset_txd_odd: got %b want 1", txd_o); end
    reset_n = 1;
  endtask

  task automatic test_basic_frame;
    step(1, 8'hA5, 0, 0, 0);
    n_chk++; if (buf_full_e !== 1'b1) begin n_fail++; $display("FAIL a5_buf_full: got %b want 1", buf_full_e); end
    send(0, 8'h00);
    n_chk++; if (oe !== 12'hD4A) begin n_fail++; $display("FAIL a5_frame: got %h want d4a", oe); end
    n_chk++; if (n12_mid !== 1'b0) begin n_fail++; $display("FAIL a5_num12_mid: got %b want 0", n12_mid); end
    n_chk++; if (n12_end !== 1'b1) begin n_fail++; $display("FAIL a5_num12_end: got %b want 1", n12_end); end
    n_chk++; if (txd_end !== 1'b1) begin n_fail++; $display("FAIL a5_txd_end: got %b want 1", txd_end); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL a5_buf_empty: got %b want 0", buf_full_e); end
    n_chk++; if (underrun_e !== 1'b0) begin n_fail++; $display("FAIL a5_underrun: got %b want 0", underrun_e); end
  endtask

  task automatic test_parity_odd;
    step(1, 8'h00, 0, 0, 0);
    send(0, 8'h00);
    n_chk++; if (oo !== 12'hE00) begin n_fail++; $display("FAIL odd_00_frame: got %h want e00", oo); end
    n_chk++; if (oe !== 12'hC00) begin n_fail++; $display("FAIL even_00_frame: got %h want c00", oe); end
  endtask

  task automatic test_overrun;
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    n_chk++; if (overrun_e !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun_e); end
    n_chk++; if (buf_full_e !== 1'b1) begin n_fail++; $display("FAIL ovr_buf_full: got %b want 1", buf_full_e); end
    send(0, 8'h00);
    n_chk++; if (oe !== 12'hC22) begin n_fail++; $display("FAIL ovr_frame: got %h want c22", oe); end
    n_chk++; if (oo !== 12'hE22) begin n_fail++; $display("FAIL ovr_frame_odd: got %h want e22", oo); end
    step(0, 8'h00, 0, 0, 1);
    n_chk++; if (overrun_e !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun_e); end
  endtask

  task automatic test_flag_priority;
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 1);
    n_chk++; if (overrun_e !== 1'b1) begin n_fail++; $display("FAIL prio_set_wins: got %b want 1", overrun_e); end
    step(0, 8'h00, 0, 0, 1);
    n_chk++; if (overrun_e !== 1'b0) begin n_fail++; $display("FAIL prio_clear: got %b want 0", overrun_e); end
    send(0, 8'h00);
  endtask

  task automatic test_underrun;
    send(0, 8'h00);
    n_chk++; if (underrun_e !== 1'b1) begin n_fail++; $display("FAIL und_set: got %b want 1", underrun_e); end
    n_chk++; if (oe !== 12'hFFF) begin n_fail++; $display("FAIL und_line_idle: got %h want fff", oe); end
    n_chk++; if (n12_end !== 1'b1) begin n_fail++; $display("FAIL und_num12: got %b want 1", n12_end); end
    n_chk++; if (overrun_e !== 1'b0) begin n_fail++; $display("FAIL und_no_ovr: got %b want 0", overrun_e); end
    step(0, 8'h00, 0, 0, 1);
    n_chk++; if (underrun_e !== 1'b0) begin n_fail++; $display("FAIL und_clear: got %b want 0", underrun_e); end
  endtask

  task automatic test_back_to_back;
    step(1, 8'h33, 0, 0, 0);
    send(1, 8'h44);
    n_chk++; if (oe !== 12'hC66) begin n_fail++; $display("FAIL b2b_first: got %h want c66", oe); end
    n_chk++; if (buf_full_e !== 1'b1) begin n_fail++; $display("FAIL b2b_buf_full: got %b want 1", buf_full_e); end
    n_chk++; if (overrun_e !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovr: got %b want 0", overrun_e); end
    send(0, 8'h00);
    n_chk++; if (oe !== 12'hC88) begin n_fail++; $display("FAIL b2b_second: got %h want c88", oe); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", buf_full_e); end
  endtask

  task automatic test_abort_direct;
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    repeat (3) step(0, 8'h00, 0, 1, 0);
    send(1, 8'h11);
    n_chk++; if (oe !== 12'hC22) begin n_fail++; $display("FAIL abort_direct_frame: got %h want c22", oe); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL abort_direct_buf: got %b want 0", buf_full_e); end
    n_chk++; if (underrun_e !== 1'b0) begin n_fail++; $display("FAIL abort_direct_und: got %b want 0", underrun_e); end
  endtask

  task automatic test_reset_mid_frame;
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    repeat (4) step(0, 8'h00, 0, 1, 0);
    step(1, 8'h66, 0, 1, 0);
    n_chk++; if (txd_e !== 1'b0) begin n_fail++; $display("FAIL mid_txd_before: got %b want 0", txd_e); end
    n_chk++; if (buf_full_e !== 1'b1) begin n_fail++; $display("FAIL mid_buf_before: got %b want 1", buf_full_e); end
    reset_n = 0;
    #1;
    n_chk++; if (txd_e !== 1'b1) begin n_fail++; $display("FAIL async_txd: got %b want 1", txd_e); end
    n_chk++; if (num12_e !== 1'b1) begin n_fail++; $display("FAIL async_num12: got %b want 1", num12_e); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL async_buf: got %b want 0", buf_full_e); end
    #1;
    reset_n = 1;
    step(0, 8'h00, 0, 1, 0);
    n_chk++; if (num12_e !== 1'b1) begin n_fail++; $display("FAIL post_rst_num12: got %b want 1", num12_e); end
    n_chk++; if (txd_e !== 1'b1) begin n_fail++; $display("FAIL post_rst_txd: got %b want 1", txd_e); end
    n_chk++; if (buf_full_e !== 1'b0) begin n_fail++; $display("FAIL post_rst_buf: got %b want 0", buf_full_e); end
  endtask

  initial begin
    #2;
    test_reset;
    test_basic_frame;
    test_parity_odd;
    test_overrun;
    test_flag_priority;
    test_underrun;
    test_back_to_back;
    test_abort_direct;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
